// File: rtl/xz_sampler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : xz_sampler_pkg
//  Purpose  : Shared types for the X/Z bus sampler: the resolved bus shape,
//             the queued sample record, the control FSM states and a
//             popcount helper for the unknown-bit mask.
//  Revision : 1.0  initial release
// ============================================================================
package xz_sampler_pkg;

  localparam int BUS_W = 24;

  typedef logic [2:4][3:2][0:1][3:2] bus_t;
  typedef logic [4:0]                xzcnt_t;

  typedef struct packed {
    bus_t   clean;
    bus_t   mask;
    xzcnt_t cnt;
  } sample_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_t;

  // Number of set bits in a mask; the bus shape is flattened first.
  function automatic xzcnt_t xz_popcount(input bus_t m);
    logic [BUS_W-1:0] flat;
    xzcnt_t           n;
    flat = m;
    n    = '0;
    for (int i = 0; i < BUS_W; i++) begin
      n = n + xzcnt_t'(flat[i]);
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xz_bus_sampler_if.sv
`default_nettype none
// ============================================================================
//  Module   : xz_bus_sampler_if
//  Purpose  : Input and output stream handshakes of the X/Z bus sampler.
//             master = the environment driving samples and accepting
//             results, slave = the sampler stage.
//  Revision : 1.0  initial release
// ============================================================================
interface xz_bus_sampler_if;
  import xz_sampler_pkg::*;

  logic   in_valid;
  logic   in_ready;
  bus_t   in_bus;
  logic   out_valid;
  logic   out_ready;
  bus_t   out_clean;
  bus_t   out_xz_mask;
  xzcnt_t out_xz_count;

  modport master (
    output in_valid, in_bus, out_ready,
    input  in_ready, out_valid, out_clean, out_xz_mask, out_xz_count
  );

  modport slave (
    input  in_valid, in_bus, out_ready,
    output in_ready, out_valid, out_clean, out_xz_mask, out_xz_count
  );

endinterface
`default_nettype wire

// File: rtl/xz_bus_sampler_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : xz_sample_fifo
//  Purpose  : Small synchronous FIFO of sample_t records. The head is read
//             combinationally from storage so a pushed entry is visible the
//             cycle after the push. DEPTH must be a power of two (>= 2) so
//             the pointers wrap by natural overflow.
//  Revision : 1.0  initial release
// ============================================================================
module xz_sample_fifo
  import xz_sampler_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  wire     clk,
  input  wire     rst_n,
  input  wire     i_push,
  input  wire     i_pop,
  input  sample_t i_din,
  output sample_t o_dout,
  output logic    o_full,
  output logic    o_empty
);

  localparam int             c_ADDR_W = $clog2(DEPTH);
  localparam logic [c_ADDR_W:0] c_FULL = (c_ADDR_W + 1)'(DEPTH);

  sample_t               r_mem [DEPTH];
  logic [c_ADDR_W-1:0]   r_wr_ptr;
  logic [c_ADDR_W-1:0]   r_rd_ptr;
  logic [c_ADDR_W:0]     r_count;

  // Pointer and occupancy tracking; reset empties the queue at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == c_FULL);
  assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/xz_bus_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : xz_bus_sampler
//  Purpose  : Samples the 4-state resolved bus under valid/ready, marks
//             every X/Z bit, substitutes a clean value for it and queues
//             {clean, mask, count} for the next stage. Tracks a saturating
//             sample count and a sticky too-many-unknowns flag. A flush
//             drains the queue and clears the substitution history.
//  Option   : XZ_HOLD_LAST_EN - unknown bits take the last clean value of
//             that bit instead of 0.
//  Revision : 1.0  initial release
// ============================================================================
module xz_bus_sampler
  import xz_sampler_pkg::*;
#(
  parameter int W          = 24,
  parameter int DEPTH      = 2,
  parameter int CNT_W      = 8,
  parameter int ERR_THRESH = 4
) (
  input  wire               clk,
  input  wire               rst_n,
  input  wire               flush,
  xz_bus_sampler_if.slave   bus,
  output logic              sticky_err,
  output logic [CNT_W-1:0]  total_samples
);

  state_t         r_state;
  state_t         w_state_nxt;
  logic           w_full;
  logic           w_empty;
  logic           w_in_ready;
  logic           w_push;
  logic           w_pop;
  logic [W-1:0]   w_in_flat;
  logic [W-1:0]   w_mask;
  logic [W-1:0]   w_sub;
  logic [W-1:0]   w_clean;
  xzcnt_t         w_cnt;
  sample_t        w_din;
  sample_t        w_dout;

  assign w_in_flat  = bus.in_bus;
  assign w_in_ready = !w_full && (r_state == RUN);
  assign w_push     = bus.in_valid && w_in_ready;
  assign w_pop      = !w_empty && bus.out_ready;

`ifdef XZ_HOLD_LAST_EN
  logic [W-1:0] r_last_clean;

  // Substitution history: follows each accepted word, wiped by CLEAR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_last_clean <= '0;
    else if (r_state == CLEAR)  r_last_clean <= '0;
    else if (w_push)            r_last_clean <= w_clean;
  end

  assign w_sub = r_last_clean;
`else
  assign w_sub = '0;
`endif

  // Per-bit classification: anything that is not a definite 0/1 is unknown.
  always_comb begin
    w_mask  = '0;
    w_clean = '0;
    for (int i = 0; i < W; i++) begin
      w_mask[i]  = (w_in_flat[i] !== 1'b0) && (w_in_flat[i] !== 1'b1);
      w_clean[i] = w_mask[i] ? w_sub[i] : w_in_flat[i];
    end
  end

  assign w_cnt       = xz_popcount(w_mask);
  assign w_din.clean = w_clean;
  assign w_din.mask  = w_mask;
  assign w_din.cnt   = w_cnt;

  xz_sample_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_din),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Saturating sample counter and sticky error, both cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_samples <= '0;
      sticky_err    <= 1'b0;
    end else if (w_push) begin
      if (total_samples != '1) total_samples <= total_samples + 1'b1;
      if (int'(w_cnt) > ERR_THRESH) sticky_err <= 1'b1;
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  // Flush sequencing: stop accepting, drain, spend one cycle clearing.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (flush)   w_state_nxt = DRAIN;
      DRAIN:   if (w_empty) w_state_nxt = CLEAR;
      CLEAR:   w_state_nxt = flush ? DRAIN : RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // Head outputs read as zero while the queue is empty.
  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = !w_empty;
  assign bus.out_clean    = w_empty ? '0 : w_dout.clean;
  assign bus.out_xz_mask  = w_empty ? '0 : w_dout.mask;
  assign bus.out_xz_count = w_empty ? '0 : w_dout.cnt;

endmodule
`default_nettype wire

// File: tb/tb_xz_bus_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xz_bus_sampler
//  Purpose  : Scoreboard bench for xz_bus_sampler. Accepted samples push an
//             expected record computed from the bit classification rules;
//             a monitor pops and compares on every output handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_xz_bus_sampler;
  import xz_sampler_pkg::*;

  localparam int c_SAT = 255;

  typedef struct {
    logic [23:0] clean;
    logic [23:0] mask;
    logic [4:0]  cnt;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       sticky_err;
  logic [7:0] total_samples;

  xz_bus_sampler_if bif ();

  xz_bus_sampler #(
    .W          (24),
    .DEPTH      (2),
    .CNT_W      (8),
    .ERR_THRESH (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .bus           (bif),
    .sticky_err    (sticky_err),
    .total_samples (total_samples)
  );

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          m_total = 0;
  bit          m_sticky = 0;
  logic [23:0] m_last = '0;
  bit          ready_rand = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected record from the classification rules: known bits pass,
  // unknown bits take the substitute (history or zero).
  function automatic exp_t model(input logic [23:0] v, input logic [23:0] last);
    exp_t e;
    int   n = 0;
    for (int i = 0; i < 24; i++) begin
      if (v[i] === 1'b0 || v[i] === 1'b1) begin
        e.clean[i] = v[i];
        e.mask[i]  = 1'b0;
      end else begin
        e.mask[i] = 1'b1;
        n++;
`ifdef XZ_HOLD_LAST_EN
        e.clean[i] = last[i];
`else
        e.clean[i] = 1'b0;
`endif
      end
    end
    e.cnt = 5'(n);
    return e;
  endfunction

  // Offer one sample until accepted (bounded); update the reference model.
  task automatic send(input logic [23:0] v);
    bit   done = 0;
    exp_t e;
    bif.in_valid = 1'b1;
    bif.in_bus   = v;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      chk("total_samples", 32'(total_samples), 32'(m_total));
      chk("sticky_err", 32'(sticky_err), 32'(m_sticky));
      if (bif.in_ready) begin
        e = model(v, m_last);
        q.push_back(e);
        m_last = e.clean;
        if (m_total < c_SAT) m_total++;
        if (e.cnt > 5'd4) m_sticky = 1'b1;
        done = 1;
      end
      @(posedge clk); #1;
    end
    bif.in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=no_accept required=accept at %0t", $time);
    end
  endtask

  // Monitor: every output handshake must match the oldest expected record.
  always @(negedge clk) begin
    if (rst_n && bif.out_valid && bif.out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%h required=none", bif.out_clean);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_clean", 32'(bif.out_clean), 32'(e.clean));
        chk("out_xz_mask", 32'(bif.out_xz_mask), 32'(e.mask));
        chk("out_xz_count", 32'(bif.out_xz_count), 32'(e.cnt));
      end
    end
  end

  always @(posedge clk) begin
    if (ready_rand) begin
      #1 bif.out_ready = (($urandom % 4) != 0);
    end
  end

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [23:0] v;
    logic [23:0] held;
    bit          seen;

    rst_n        = 1'b0;
    flush        = 1'b0;
    bif.in_valid = 1'b0;
    bif.in_bus   = '0;
    bif.out_ready = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst_out_valid", 32'(bif.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bif.in_ready), 32'd1);
    chk("rst_out_clean", 32'(bif.out_clean), 32'd0);
    chk("rst_out_mask", 32'(bif.out_xz_mask), 32'd0);
    chk("rst_out_count", 32'(bif.out_xz_count), 32'd0);
    chk("rst_sticky", 32'(sticky_err), 32'd0);
    chk("rst_total", 32'(total_samples), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // Fully known word appears one cycle after acceptance.
    bif.out_ready = 1'b1;
    send(24'h00A5F0);
    @(negedge clk);
    chk("lat_out_valid", 32'(bif.out_valid), 32'd1);
    chk("lat_out_clean", 32'(bif.out_clean), 32'h00A5F0);
    chk("lat_total", 32'(total_samples), 32'd1);
    @(posedge clk); #1;

    // Unknown top nibble after a prior clean word.
    send(24'hF00000);
    v = 24'h00000F;
    v[23:20] = 4'bxxxx;
    send(v);
    idle(2);

    // Five unknown bits trip the sticky flag; it survives clean traffic.
    v = 24'h123456;
    v[0] = 1'bx; v[3] = 1'bx; v[7] = 1'bx; v[10] = 1'bx; v[15] = 1'bx;
    send(v);
    for (int i = 0; i < 10; i++) send(24'($urandom));
    idle(3);

    // Backpressure: two entries fill the queue, third waits.
    bif.out_ready = 1'b0;
    send(24'h111111);
    send(24'h222222);
    bif.in_valid = 1'b1;
    bif.in_bus   = 24'h333333;
    @(negedge clk);
    chk("full_in_ready", 32'(bif.in_ready), 32'd0);
    chk("full_head", 32'(bif.out_clean), 32'h111111);
    held = bif.out_clean;
    @(posedge clk); #1;
    bif.out_ready = 1'b1;
    @(negedge clk);
    chk("stall_hold", 32'(held), 32'(bif.out_clean));
    chk("full_ready_hi", 32'(bif.in_ready), 32'd0);
    @(posedge clk); #1;
    send(24'h333333);
    idle(4);

    // Flush with two entries queued.
    bif.out_ready = 1'b0;
    send(24'h0AAAAA);
    send(24'h055555);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("drain_in_ready", 32'(bif.in_ready), 32'd0);
    @(posedge clk); #1;
    bif.out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (bif.in_ready) seen = 1;
      else if (bif.out_valid) chk("drain_block", 32'(bif.in_ready), 32'd0);
    end
    chk("drain_ends", 32'(seen), 32'd1);
    m_last = '0;
    @(posedge clk); #1;
    send(24'hxxxxxx);
    idle(3);

    // Flush on an empty queue: DRAIN and CLEAR block, then RUN.
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("eflush_drain", 32'(bif.in_ready), 32'd0);
    @(negedge clk);
    chk("eflush_clear", 32'(bif.in_ready), 32'd0);
    @(negedge clk);
    chk("eflush_run", 32'(bif.in_ready), 32'd1);
    m_last = '0;
    @(posedge clk); #1;

    // Random traffic with sporadic unknown bits; counter saturates.
    ready_rand = 1;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 24; i++) v[i] = (($urandom % 16) == 0) ? 1'bx : 1'($urandom % 2);
      send(v);
    end
    ready_rand = 0;
    @(posedge clk); #2;
    bif.out_ready = 1'b1;
    idle(4);
    chk("sat_total", 32'(total_samples), 32'd255);

    // Fill, then reset mid-stream.
    bif.out_ready = 1'b0;
    send(24'h0F0F0F);
    send(24'hF0F0F0);
    @(negedge clk);
    chk("pre_rst_valid", 32'(bif.out_valid), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bif.out_valid), 32'd0);
    chk("arst_total", 32'(total_samples), 32'd0);
    chk("arst_sticky", 32'(sticky_err), 32'd0);
    chk("arst_in_ready", 32'(bif.in_ready), 32'd1);
    q.delete();
    m_total  = 0;
    m_sticky = 0;
    m_last   = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    bif.out_ready = 1'b1;
    send(24'h5A5A5A);
    idle(4);
    chk("post_rst_total", 32'(total_samples), 32'd1);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
